frame_capture_ctrl: RTL

FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

---
 rtl/frame_capture_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/frame_capture_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// frame_capture_ctrl : camera frame capture FSM with frame-buffer port-B
//                      arbitration between display and decoder readers.
// Revision 1.0
// ----------------------------------------------------------------------------
module frame_capture_ctrl #(
  parameter int STORED_WIDTH  = 480,
  parameter int STORED_HEIGHT = 480
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        capture_req_in,
  input  logic        release_in,
  input  logic        frame_done_in,
  input  logic        pix_valid_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic        we_out,
  output logic [17:0] waddr_out,
  input  logic        disp_en_in,
  input  logic [17:0] disp_addr_in,
  input  logic        dec_req_in,
  input  logic [17:0] dec_addr_in,
  output logic        dec_grant_out,
  output logic        rd_en_out,
  output logic [17:0] rd_addr_out,
  input  logic        rd_data_in,
  output logic        dec_data_out,
  output logic        dec_data_valid_out,
  output logic        frame_ready_out,
  output logic        capture_err_out,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [10:0] WIN_W        = 11'(STORED_WIDTH);
  localparam logic [9:0]  WIN_H        = 10'(STORED_HEIGHT);
  localparam logic [17:0] ROW_STRIDE   = 18'(STORED_WIDTH);
  localparam logic [17:0] FRAME_PIXELS = 18'(STORED_WIDTH * STORED_HEIGHT);

  state_t      state;
  logic [17:0] pix_count;
  logic [17:0] count_next;
  logic [17:0] pix_addr;
  logic        in_window;
  logic [1:0]  valid_pipe;

  assign in_window  = pix_valid_in && (hcount_in < WIN_W) && (vcount_in < WIN_H);
  assign pix_addr   = {7'd0, hcount_in} + ROW_STRIDE * {8'd0, vcount_in};
  // Count as it will stand after this cycle, so a pixel coincident with
  // end-of-frame is still included in the error check.
  assign count_next = pix_count + {17'd0, in_window};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= IDLE;
      pix_count       <= 18'd0;
      frame_ready_out <= 1'b0;
      capture_err_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (capture_req_in) begin
            state           <= ARM;
            capture_err_out <= 1'b0;
          end
        end
        ARM: begin
          if (frame_done_in) begin
            state     <= CAPTURE;
            pix_count <= 18'd0;
          end
        end
        CAPTURE: begin
          pix_count <= count_next;
          if (frame_done_in) begin
            state           <= HOLD;
            frame_ready_out <= 1'b1;
            capture_err_out <= (count_next != FRAME_PIXELS);
          end
        end
        HOLD: begin
          if (release_in) begin
            state           <= IDLE;
            frame_ready_out <= 1'b0;
          end
        end
        default: begin
          state           <= IDLE;
          frame_ready_out <= 1'b0;
        end
      endcase
    end
  end

  assign state_out = state;

  // Write port: the held frame is frozen, every other state streams pixels.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      we_out    <= 1'b0;
      waddr_out <= 18'd0;
    end else begin
      we_out <= in_window && (state != HOLD);
      if (in_window && (state != HOLD)) begin
        waddr_out <= pix_addr;
      end
    end
  end

  always_comb begin
    rd_en_out     = 1'b0;
    rd_addr_out   = 18'd0;
    dec_grant_out = 1'b0;
    if (disp_en_in) begin
      rd_en_out   = 1'b1;
      rd_addr_out = disp_addr_in;
    end else if (dec_req_in && (state == HOLD)) begin
      dec_grant_out = 1'b1;
      rd_en_out     = 1'b1;
      rd_addr_out   = dec_addr_in;
    end
  end

  // Tracks decoder grants across the two-cycle buffer read latency.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_pipe <= 2'b00;
    end else begin
      valid_pipe <= {valid_pipe[0], dec_grant_out};
    end
  end

  assign dec_data_valid_out = valid_pipe[1];
  assign dec_data_out       = valid_pipe[1] & rd_data_in;

endmodule
`default_nettype wire
